// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution row sequencer.
// The enum and helpers are imported by the sequencer top and its window tracker.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_TAIL,
    S_FLUSH,
    S_DONE
  } seq_state_t;

  localparam int DEF_KER_SIZE    = 3;
  localparam int DEF_INPUT_X_DIM = 28;
  localparam int DEF_PAD         = 1;
  localparam int PADDED_X        = DEF_INPUT_X_DIM + 2*DEF_PAD;

  function automatic int padded_x(input int x, input int pad);
    return x + 2*pad;
  endfunction

  function automatic int calc_win_per_row(input int x, input int pad, input int k, input int s);
    return (x + 2*pad - k) / s + 1;
  endfunction

endpackage

// File: rtl/win_col_tracker.sv
// Turns the padded column of an advancing cycle into the window strobe, its
// start column and the right-padding mask. Stride phase restarts every row.
module win_col_tracker
  import conv_pkg::*;
#(
  parameter int KER_SIZE    = DEF_KER_SIZE,
  parameter int STRIDE      = 1,
  parameter int INPUT_X_DIM = DEF_INPUT_X_DIM,
  parameter int PAD         = DEF_PAD,
  parameter int PX          = PADDED_X,
  parameter int AW          = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_adv,
  input  logic                i_lb_ready,
  input  logic [AW-1:0]       i_pcol,
  output logic                o_win_valid,
  output logic [AW-1:0]       o_win_col,
  output logic [KER_SIZE-1:0] o_right_pad_mask
);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [SW-1:0] r_phase;
  logic          w_in_range;
  logic          w_row_end;
  logic [AW-1:0] w_s;

  assign w_in_range = (i_pcol >= AW'(KER_SIZE-1));
  assign w_s        = i_pcol - AW'(KER_SIZE-1);
  assign w_row_end  = i_adv && (i_pcol == AW'(PX-1));

  // Phase equals s mod STRIDE because s steps by one on every advancing cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (i_adv) begin
      if (w_row_end)
        r_phase <= '0;
      else if (w_in_range)
        r_phase <= (r_phase == SW'(STRIDE-1)) ? '0 : r_phase + SW'(1);
    end
  end

  assign o_win_valid = i_lb_ready && i_adv && w_in_range && (r_phase == '0);
  assign o_win_col   = o_win_valid ? w_s : '0;

  for (genvar j = 0; j < KER_SIZE; j++) begin : g_mask
    assign o_right_pad_mask[j] = o_win_valid && ((int'(w_s) + j) >= (INPUT_X_DIM + PAD));
  end

endmodule

// File: rtl/conv_row_sequencer.sv
// Walks one feature map through the line buffer: input rows, right-pad tail
// cycles, bottom-pad zero rows, then a one-cycle frame_done.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int KER_SIZE    = DEF_KER_SIZE,
  parameter int STRIDE      = 1,
  parameter int INPUT_X_DIM = DEF_INPUT_X_DIM,
  parameter int PAD         = DEF_PAD,
  parameter int AW          = 5,
  parameter int RW          = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mac_ready,
  input  logic                lb_ready,
  output logic                lb_valid,
  output logic                lb_zero,
  output logic                win_valid,
  output logic [AW-1:0]       win_col,
  output logic [KER_SIZE-1:0] right_pad_mask,
  output logic                busy,
  output logic                frame_done
);
  localparam int  TW     = (PAD > 1) ? $clog2(PAD) : 1;
  localparam int  PADM1  = (PAD > 0) ? PAD - 1 : 0;
  localparam bit  NO_PAD = (PAD == 0);

  seq_state_t    r_state;
  logic [AW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [TW-1:0] r_tail;
  logic          r_frame_done;

  logic          w_run, w_tail, w_flush;
  logic          w_accept, w_fwrite, w_tadv, w_adv;
  logic          w_last_col, w_last_tail;
  logic [AW-1:0] w_pcol;

  assign w_run       = (r_state == S_RUN);
  assign w_tail      = (r_state == S_TAIL);
  assign w_flush     = (r_state == S_FLUSH);
  assign w_accept    = w_run && in_valid && mac_ready;
  assign w_fwrite    = w_flush && mac_ready;
  assign w_tadv      = w_tail && mac_ready;
  assign w_adv       = w_accept || w_fwrite || w_tadv;
  assign w_last_col  = (r_col == AW'(INPUT_X_DIM-1));
  assign w_last_tail = (r_tail == TW'(PADM1));
  assign w_pcol      = w_tail ? AW'(INPUT_X_DIM + PAD) + AW'(r_tail) : r_col + AW'(PAD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_tail       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_col   <= '0;
          r_row   <= '0;
          r_tail  <= '0;
        end
        S_RUN: if (w_accept) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
            if (!NO_PAD) begin
              r_state <= S_TAIL;
            end else if (r_row == RW'(INPUT_X_DIM-1)) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end else begin
            r_col <= r_col + AW'(1);
          end
        end
        S_TAIL: if (mac_ready) begin
          if (w_last_tail) begin
            r_tail <= '0;
            // r_row already counts the row this tail closes
            if (r_row < RW'(INPUT_X_DIM)) begin
              r_state <= S_RUN;
            end else if (r_row < RW'(INPUT_X_DIM + PAD)) begin
              r_state <= S_FLUSH;
            end else begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end else begin
            r_tail <= r_tail + TW'(1);
          end
        end
        S_FLUSH: if (mac_ready) begin
          if (w_last_col) begin
            r_col   <= '0;
            r_row   <= r_row + RW'(1);
            r_state <= S_TAIL;
          end else begin
            r_col <= r_col + AW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  win_col_tracker #(
    .KER_SIZE   (KER_SIZE),
    .STRIDE     (STRIDE),
    .INPUT_X_DIM(INPUT_X_DIM),
    .PAD        (PAD),
    .PX         (padded_x(INPUT_X_DIM, PAD)),
    .AW         (AW)
  ) u_win (
    .clk             (clk),
    .rstn            (rstn),
    .i_adv           (w_adv),
    .i_lb_ready      (lb_ready),
    .i_pcol          (w_pcol),
    .o_win_valid     (win_valid),
    .o_win_col       (win_col),
    .o_right_pad_mask(right_pad_mask)
  );

  assign in_ready   = w_run && mac_ready;
  assign lb_valid   = w_accept || w_fwrite;
  assign lb_zero    = w_fwrite;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed bench: default 28x28 frame, stall run, stride-2 and no-pad variants,
// and an asynchronous reset in the middle of a frame.
module tb_conv_row_sequencer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, mac_ready = 1'b0, lb_ready = 1'b0;
  logic st_d = 1'b0, st_s = 1'b0, st_p = 1'b0;

  logic       d_in_ready, d_lb_valid, d_lb_zero, d_win_valid, d_busy, d_frame_done;
  logic [4:0] d_win_col;
  logic [2:0] d_mask;
  logic       s_in_ready, s_lb_valid, s_lb_zero, s_win_valid, s_busy, s_frame_done;
  logic [4:0] s_win_col;
  logic [2:0] s_mask;
  logic       p_in_ready, p_lb_valid, p_lb_zero, p_win_valid, p_busy, p_frame_done;
  logic [4:0] p_win_col;
  logic [2:0] p_mask;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_row_sequencer #(.KER_SIZE(3), .STRIDE(1), .INPUT_X_DIM(28), .PAD(1), .AW(5), .RW(8)) u_def (
    .clk(clk), .rstn(rstn), .start(st_d), .in_valid(in_valid), .in_ready(d_in_ready),
    .mac_ready(mac_ready), .lb_ready(lb_ready), .lb_valid(d_lb_valid), .lb_zero(d_lb_zero),
    .win_valid(d_win_valid), .win_col(d_win_col), .right_pad_mask(d_mask),
    .busy(d_busy), .frame_done(d_frame_done));

  conv_row_sequencer #(.KER_SIZE(3), .STRIDE(2), .INPUT_X_DIM(8), .PAD(1), .AW(5), .RW(8)) u_s2 (
    .clk(clk), .rstn(rstn), .start(st_s), .in_valid(in_valid), .in_ready(s_in_ready),
    .mac_ready(mac_ready), .lb_ready(lb_ready), .lb_valid(s_lb_valid), .lb_zero(s_lb_zero),
    .win_valid(s_win_valid), .win_col(s_win_col), .right_pad_mask(s_mask),
    .busy(s_busy), .frame_done(s_frame_done));

  conv_row_sequencer #(.KER_SIZE(3), .STRIDE(1), .INPUT_X_DIM(6), .PAD(0), .AW(5), .RW(8)) u_p0 (
    .clk(clk), .rstn(rstn), .start(st_p), .in_valid(in_valid), .in_ready(p_in_ready),
    .mac_ready(mac_ready), .lb_ready(lb_ready), .lb_valid(p_lb_valid), .lb_zero(p_lb_zero),
    .win_valid(p_win_valid), .win_col(p_win_col), .right_pad_mask(p_mask),
    .busy(p_busy), .frame_done(p_frame_done));

  // Default geometry: window column c covers padded columns c..c+2; column 29 is padding.
  function automatic logic [2:0] def_mask(input int c);
    logic [2:0] m;
    for (int j = 0; j < 3; j++) m[j] = (c + j >= 29);
    return m;
  endfunction

  task automatic test_reset();
    logic [12:0] v;
    rstn = 1'b0;
    #12;
    v = {d_in_ready, d_lb_valid, d_lb_zero, d_win_valid, d_win_col, d_mask, d_busy, d_frame_done};
    n_chk++; if (v !== 13'd0) begin n_fail++; $display("FAIL reset_def: got %h want 0", v); end
    v = {s_in_ready, s_lb_valid, s_lb_zero, s_win_valid, s_win_col, s_mask, s_busy, s_frame_done};
    n_chk++; if (v !== 13'd0) begin n_fail++; $display("FAIL reset_s2: got %h want 0", v); end
    v = {p_in_ready, p_lb_valid, p_lb_zero, p_win_valid, p_win_col, p_mask, p_busy, p_frame_done};
    n_chk++; if (v !== 13'd0) begin n_fail++; $display("FAIL reset_p0: got %h want 0", v); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  // 28 input rows + 1 zero row, each 28 writes + 1 tail cycle: 29*29 = 841 active cycles.
  task automatic test_full_frame();
    int nwin = 0, nwr = 0, nz = 0, ntail = 0, ndone = 0, done_at = -1, bad = 0;
    bit chk_tail = 0;
    in_valid = 1'b1; mac_ready = 1'b1; lb_ready = 1'b0;
    @(negedge clk); st_d = 1'b1;
    @(negedge clk); st_d = 1'b0;
    for (int cyc = 0; cyc < 1000 && done_at < 0; cyc++) begin
      lb_ready = (cyc >= 29);
      st_d = (cyc == 100);
      #1;
      if (chk_tail) begin
        chk_tail = 0;
        n_chk++;
        if ({d_in_ready, d_lb_valid, d_win_valid, d_win_col, d_mask} !== {1'b0, 1'b0, 1'b1, 5'd27, 3'b100}) begin
          n_fail++;
          $display("FAIL row5_tail: rdy=%b lbv=%b wv=%b col=%0d mask=%b want 0 0 1 27 100",
                   d_in_ready, d_lb_valid, d_win_valid, d_win_col, d_mask);
        end
      end
      if (d_lb_valid && !d_lb_zero && nwr == 5*28+27) begin
        chk_tail = 1;
        n_chk++;
        if ({d_win_valid, d_win_col, d_mask} !== {1'b1, 5'd26, 3'b000}) begin
          n_fail++;
          $display("FAIL row5_col27: wv=%b col=%0d mask=%b want 1 26 000", d_win_valid, d_win_col, d_mask);
        end
      end
      if (d_win_valid) begin
        if (!lb_ready || d_win_col !== 5'(nwin % 28) || d_mask !== def_mask(nwin % 28)) bad++;
        nwin++;
      end
      if (d_lb_valid && d_lb_zero) nz++;
      else if (d_lb_valid) nwr++;
      if (d_busy && !d_in_ready && !d_lb_valid && !d_frame_done) ntail++;
      if (d_frame_done) begin ndone++; done_at = cyc; end
      @(negedge clk);
    end
    #1;
    n_chk++; if (nwin != 784) begin n_fail++; $display("FAIL full_win_count: got %0d want 784", nwin); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL full_win_seq: %0d bad windows want 0", bad); end
    n_chk++; if (nwr != 784) begin n_fail++; $display("FAIL full_writes: got %0d want 784", nwr); end
    n_chk++; if (nz != 28) begin n_fail++; $display("FAIL full_zero_writes: got %0d want 28", nz); end
    n_chk++; if (ntail != 29) begin n_fail++; $display("FAIL full_tail_cycles: got %0d want 29", ntail); end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", ndone); end
    n_chk++;
    if (done_at < 840 || done_at > 842) begin n_fail++; $display("FAIL full_done_latency: got %0d want 841", done_at); end
    n_chk++;
    if ({d_busy, d_frame_done} !== 2'b00) begin n_fail++; $display("FAIL full_idle_after: got %b want 00", {d_busy, d_frame_done}); end
    lb_ready = 1'b0;
  endtask

  task automatic test_stall();
    int nwin = 0, nacc = 0, nz = 0, ntadv = 0, ndone = 0, done_at = -1, bad_seq = 0, bad_stall = 0;
    lb_ready = 1'b1; in_valid = 1'b1; mac_ready = 1'b1;
    @(negedge clk); st_d = 1'b1;
    @(negedge clk); st_d = 1'b0;
    for (int cyc = 0; cyc < 6000 && done_at < 0; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mac_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (d_win_valid && !mac_ready) bad_stall++;
      if (d_lb_valid && !mac_ready) bad_stall++;
      if (d_lb_valid && !d_lb_zero && !(in_valid && d_in_ready)) bad_stall++;
      if (d_win_valid) begin
        if (d_win_col !== 5'(nwin % 28) || d_mask !== def_mask(nwin % 28)) bad_seq++;
        nwin++;
      end
      if (in_valid && d_in_ready) nacc++;
      if (d_lb_valid && d_lb_zero) nz++;
      if (d_busy && mac_ready && !d_in_ready && !d_lb_valid && !d_frame_done) ntadv++;
      if (d_frame_done) begin ndone++; done_at = cyc; end
      @(negedge clk);
    end
    in_valid = 1'b1; mac_ready = 1'b1;
    n_chk++; if (done_at < 0) begin n_fail++; $display("FAIL stall_timeout: frame_done not seen in 6000 cycles"); end
    n_chk++; if (nwin != 812) begin n_fail++; $display("FAIL stall_win_count: got %0d want 812", nwin); end
    n_chk++; if (bad_seq != 0) begin n_fail++; $display("FAIL stall_win_seq: %0d bad windows want 0", bad_seq); end
    n_chk++; if (bad_stall != 0) begin n_fail++; $display("FAIL stall_gating: %0d violations want 0", bad_stall); end
    n_chk++; if (nacc != 784) begin n_fail++; $display("FAIL stall_accepts: got %0d want 784", nacc); end
    n_chk++; if (nz != 28) begin n_fail++; $display("FAIL stall_zero_writes: got %0d want 28", nz); end
    n_chk++; if (ntadv != 29) begin n_fail++; $display("FAIL stall_tail_adv: got %0d want 29", ntadv); end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", ndone); end
    lb_ready = 1'b0;
  endtask

  // X=8, PAD=1, K=3, S=2: 9 rows of 9 cycles, windows at s = 0,2,4,6.
  task automatic test_stride2();
    int nwin = 0, bad = 0, ndone = 0, done_at = -1;
    in_valid = 1'b1; mac_ready = 1'b1; lb_ready = 1'b0;
    @(negedge clk); st_s = 1'b1;
    @(negedge clk); st_s = 1'b0;
    for (int cyc = 0; cyc < 200 && done_at < 0; cyc++) begin
      lb_ready = (cyc >= 9);
      #1;
      if (s_win_valid) begin
        if (!lb_ready || s_win_col !== 5'((nwin % 4) * 2) || s_mask !== 3'b000) bad++;
        nwin++;
      end
      if (s_frame_done) begin ndone++; done_at = cyc; end
      @(negedge clk);
    end
    n_chk++; if (nwin != 32) begin n_fail++; $display("FAIL s2_win_count: got %0d want 32", nwin); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL s2_win_seq: %0d bad windows want 0", bad); end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL s2_done_count: got %0d want 1", ndone); end
    n_chk++;
    if (done_at < 80 || done_at > 82) begin n_fail++; $display("FAIL s2_done_latency: got %0d want 81", done_at); end
    lb_ready = 1'b0;
  endtask

  // X=6, PAD=0: no tail, no zero rows, windows at s = 0..3 per row.
  task automatic test_pad0();
    int nwin = 0, bad = 0, nz = 0, ntail = 0, nwr = 0, ndone = 0, done_at = -1;
    in_valid = 1'b1; mac_ready = 1'b1; lb_ready = 1'b1;
    @(negedge clk); st_p = 1'b1;
    @(negedge clk); st_p = 1'b0;
    for (int cyc = 0; cyc < 200 && done_at < 0; cyc++) begin
      #1;
      if (p_win_valid) begin
        if (p_win_col !== 5'(nwin % 4) || p_mask !== 3'b000) bad++;
        nwin++;
      end
      if (p_lb_zero) nz++;
      if (p_lb_valid) nwr++;
      if (p_busy && !p_in_ready && !p_lb_valid && !p_frame_done) ntail++;
      if (p_frame_done) begin ndone++; done_at = cyc; end
      @(negedge clk);
    end
    n_chk++; if (nwin != 24) begin n_fail++; $display("FAIL p0_win_count: got %0d want 24", nwin); end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL p0_win_seq: %0d bad windows want 0", bad); end
    n_chk++; if (nz != 0) begin n_fail++; $display("FAIL p0_lb_zero: got %0d want 0", nz); end
    n_chk++; if (ntail != 0) begin n_fail++; $display("FAIL p0_tail_cycles: got %0d want 0", ntail); end
    n_chk++; if (nwr != 36) begin n_fail++; $display("FAIL p0_writes: got %0d want 36", nwr); end
    n_chk++;
    if (ndone != 1 || done_at < 35 || done_at > 37) begin
      n_fail++; $display("FAIL p0_done: count %0d at %0d want 1 at 36", ndone, done_at);
    end
    lb_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int nwr = 0;
    bit hit = 0;
    logic [12:0] v;
    in_valid = 1'b1; mac_ready = 1'b1; lb_ready = 1'b1;
    @(negedge clk); st_d = 1'b1;
    @(negedge clk); st_d = 1'b0;
    for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
      #1;
      if (d_lb_valid && !d_lb_zero) begin
        if (nwr == 10*28+5) hit = 1;
        nwr++;
      end
      if (!hit) @(negedge clk);
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL midreset_reach: row 10 not reached"); end
    #2 rstn = 1'b0;
    #1;
    v = {d_in_ready, d_lb_valid, d_lb_zero, d_win_valid, d_win_col, d_mask, d_busy, d_frame_done};
    n_chk++; if (v !== 13'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", v); end
    @(negedge clk); rstn = 1'b1;
    test_full_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_stride2();
    test_pad0();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
